axi_mem_rw_arbiter: RTL and testbench

Sequences and shares one single-port word memory between the write path and the read path that sit behind `axi_std_slave`. It accepts burst requests (`addr`, `len`), grants one at a time and streams beats. Write beats go directly to the memory. Read beats pass through a 2-entry output buffer so `rd_ready` back-pressure never loses data. It is the sole owner of the memory port; the AXI front end only converts channel handshakes into these requests.

---
 rtl/axi_mem_rw_arbiter.sv | 170 +++++++++++++++++
 tb/tb_axi_mem_rw_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_rw_arbiter.sv
//==============================================================================
// Module   : axi_mem_rw_arbiter
// Purpose  : Shares one single-port word memory between burst write and read
//            paths; read beats drain through a 2-entry buffer.
// Config   : ARB_WR_PRIORITY_EN selects fixed write priority (default round-robin)
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module axi_mem_rw_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int MEM_ADDR_WIDTH     = 6
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          wr_req,
  input  logic [MEM_ADDR_WIDTH-1:0]     wr_addr,
  input  logic [7:0]                    wr_len,
  output logic                          wr_gnt,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          wr_done,
  input  logic                          rd_req,
  input  logic [MEM_ADDR_WIDTH-1:0]     rd_addr,
  input  logic [7:0]                    rd_len,
  output logic                          rd_gnt,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  output logic                          rd_last,
  input  logic                          rd_ready,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t                    r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [8:0]                r_cnt;
  logic                      r_wr_gnt;
  logic                      r_rd_gnt;
  logic                      r_wr_ready;
  logic                      r_wr_done;
  logic                      r_pend;
  logic                      r_pend_last;
  logic [DW-1:0]             r_buf [2];
  logic [1:0]                r_buf_last;
  logic                      r_rptr;
  logic                      r_wptr;
  logic [1:0]                r_occ;
`ifndef ARB_WR_PRIORITY_EN
  logic                      r_last_wr;
`endif

  logic       w_wr_fire;
  logic       w_rd_pop;
  logic       w_rd_issue;
  logic       w_pick_wr;
  logic [1:0] w_inflight;

`ifdef ARB_WR_PRIORITY_EN
  assign w_pick_wr = wr_req;
`else
  assign w_pick_wr = wr_req && (!rd_req || !r_last_wr);
`endif

  assign w_wr_fire  = (r_state == S_WR) && r_wr_ready && wr_valid;
  assign w_rd_pop   = (r_occ != 2'd0) && rd_ready;
  // A beat popped this cycle frees its slot, which keeps reads at one beat per cycle
  assign w_inflight = {1'b0, r_pend} + r_occ - {1'b0, w_rd_pop};
  assign w_rd_issue = (r_state == S_RD) && !r_rd_gnt && (r_cnt != 9'd0) &&
                      (w_inflight < 2'd2);

  assign mem_en    = w_wr_fire || w_rd_issue;
  assign mem_we    = w_wr_fire;
  assign mem_addr  = (w_wr_fire || w_rd_issue) ? r_addr : '0;
  assign mem_wdata = w_wr_fire ? wr_data : '0;

  assign wr_gnt   = r_wr_gnt;
  assign rd_gnt   = r_rd_gnt;
  assign wr_ready = r_wr_ready;
  assign wr_done  = r_wr_done;
  assign rd_valid = (r_occ != 2'd0);
  assign rd_data  = r_buf[r_rptr];
  assign rd_last  = (r_occ != 2'd0) && r_buf_last[r_rptr];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_wr_gnt    <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_buf_last  <= '0;
      r_rptr      <= 1'b0;
      r_wptr      <= 1'b0;
      r_occ       <= '0;
`ifndef ARB_WR_PRIORITY_EN
      r_last_wr   <= 1'b0;
`endif
    end else begin
      r_wr_gnt    <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_wr_done   <= 1'b0;
      r_pend      <= w_rd_issue;
      r_pend_last <= w_rd_issue && (r_cnt == 9'd1);
      // Memory data arrives the cycle after issue and lands in the buffer
      if (r_pend) begin
        r_buf[r_wptr]      <= mem_rdata;
        r_buf_last[r_wptr] <= r_pend_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_rd_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_rd_pop};

      case (r_state)
        S_IDLE: begin
          if (wr_req || rd_req) begin
            r_addr   <= w_pick_wr ? wr_addr : rd_addr;
            r_cnt    <= {1'b0, (w_pick_wr ? wr_len : rd_len)} + 9'd1;
            r_wr_gnt <= w_pick_wr;
            r_rd_gnt <= !w_pick_wr;
            r_state  <= w_pick_wr ? S_WR : S_RD;
`ifndef ARB_WR_PRIORITY_EN
            r_last_wr <= w_pick_wr;
`endif
          end
        end
        S_WR: begin
          if (r_wr_gnt) r_wr_ready <= 1'b1;
          if (w_wr_fire) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_wr_ready <= 1'b0;
              r_wr_done  <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_RD: begin
          if (w_rd_issue) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 9'd1;
          end
          if (w_rd_pop && r_buf_last[r_rptr]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_rw_arbiter.sv
//==============================================================================
// Module   : tb_axi_mem_rw_arbiter
// Purpose  : Directed and randomized bursts checked against a word-array model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_axi_mem_rw_arbiter;

  logic         clk;
  logic         rst_n;
  logic         wr_req, wr_gnt, wr_valid, wr_ready, wr_done;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_len;
  logic [511:0] wr_data;
  logic         rd_req, rd_gnt, rd_valid, rd_last, rd_ready;
  logic [5:0]   rd_addr;
  logic [7:0]   rd_len;
  logic [511:0] rd_data;
  logic         mem_en, mem_we;
  logic [5:0]   mem_addr;
  logic [511:0] mem_wdata, mem_rdata;

  axi_mem_rw_arbiter #(.C_S_AXI_DATA_WIDTH(512), .MEM_ADDR_WIDTH(6)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory the DUT drives; ref_mem is the independent expectation
  logic [511:0] tb_mem [64];
  logic [511:0] ref_mem [64];
  always @(posedge clk) begin
    if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
  end

  int n_pass, n_fail, n_total, n_cyc, s_cyc;
  int g_wr, g_rd, n_done, done_cyc, hs_cyc, first_rv, first_iss, last_pop_cyc;
  int n_iss, n_pop, max_out, n_unstable;
  bit s_wr_gnt, s_rd_gnt, s_wr_hs, hold_prev;
  logic [511:0] prev_data;
  logic         prev_last;
  logic [5:0]   q_waddr[$], q_raddr[$];
  logic [511:0] q_wdata[$], q_rdata[$];
  logic         q_rlast[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // One clock: sample at the falling edge, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    s_cyc    = n_cyc;
    s_wr_gnt = wr_gnt;
    s_rd_gnt = rd_gnt;
    s_wr_hs  = wr_valid && wr_ready;
    if (wr_gnt) g_wr = n_cyc;
    if (rd_gnt) g_rd = n_cyc;
    if (s_wr_hs) hs_cyc = n_cyc;
    if (wr_done) begin n_done++; done_cyc = n_cyc; end
    if (mem_en && mem_we) begin q_waddr.push_back(mem_addr); q_wdata.push_back(mem_wdata); end
    if (mem_en && !mem_we) begin
      q_raddr.push_back(mem_addr);
      n_iss++;
      if (first_iss < 0) first_iss = n_cyc;
    end
    if (rd_valid && first_rv < 0) first_rv = n_cyc;
    if (hold_prev && (!rd_valid || rd_data !== prev_data || rd_last !== prev_last)) n_unstable++;
    if (rd_valid && rd_ready) begin
      q_rdata.push_back(rd_data);
      q_rlast.push_back(rd_last);
      n_pop++;
      last_pop_cyc = n_cyc;
    end
    if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
    hold_prev = rd_valid && !rd_ready;
    prev_data = rd_data;
    prev_last = rd_last;
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  // mode 0: valid every cycle, 1: random valid, 2: directed data A0+i
  task automatic do_write(input int a, input int l, input int mode, input string tag);
    logic [511:0] bd[$];
    int i, guard, g, first_hs;
    for (int k = 0; k <= l; k++) bd.push_back(mode == 2 ? 512'(8'hA0 + k) : rnd512());
    wr_addr = 6'(a); wr_len = 8'(l); wr_req = 1'b1; g_wr = -1; guard = 0;
    while (g_wr < 0 && guard < 20) begin cyc(); guard++; end
    chk({tag, "_wgnt"}, int'(g_wr >= 0), 1);
    wr_req = 1'b0; g = g_wr;
    q_waddr.delete(); q_wdata.delete(); n_done = 0; first_hs = -1;
    i = 0; guard = 0;
    while (i <= l && guard < 3000) begin
      wr_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = bd[i];
      cyc(); guard++;
      if (s_wr_hs) begin if (first_hs < 0) first_hs = s_cyc; i++; end
    end
    wr_valid = 1'b0; wr_data = '0;
    cyc();
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_cyc"}, done_cyc, hs_cyc + 1);
    if (mode != 1) begin
      chk({tag, "_first_beat"}, first_hs, g + 1);
      chk({tag, "_last_beat"}, hs_cyc, g + 1 + l);
    end
    chk({tag, "_nwrites"}, q_waddr.size(), l + 1);
    for (int k = 0; k <= l && k < q_waddr.size(); k++) begin
      chk($sformatf("%s_waddr%0d", tag, k), int'(q_waddr[k]), (a + k) % 64);
      chkd($sformatf("%s_wdata%0d", tag, k), q_wdata[k], bd[k]);
    end
    for (int k = 0; k <= l; k++) ref_mem[(a + k) % 64] = bd[k];
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic do_read(input int a, input int l, input int mode, input string tag);
    int guard, g, k;
    logic [511:0] obs_last, exp_last;
    rd_addr = 6'(a); rd_len = 8'(l); rd_req = 1'b1; g_rd = -1; guard = 0;
    while (g_rd < 0 && guard < 20) begin cyc(); guard++; end
    chk({tag, "_rgnt"}, int'(g_rd >= 0), 1);
    rd_req = 1'b0; g = g_rd;
    q_raddr.delete(); q_rdata.delete(); q_rlast.delete();
    n_iss = 0; n_pop = 0; max_out = 0; first_rv = -1; first_iss = -1;
    n_unstable = 0; hold_prev = 0;
    k = 0; guard = 0;
    while (q_rdata.size() < l + 1 && guard < 3000) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++; guard++;
      cyc();
    end
    rd_ready = 1'b0;
    repeat (3) cyc();
    chk({tag, "_first_issue"}, first_iss, g + 1);
    chk({tag, "_first_valid"}, first_rv, g + 3);
    if (mode == 0) chk({tag, "_rate"}, last_pop_cyc, g + 3 + l);
    chk({tag, "_nbeats"}, q_rdata.size(), l + 1);
    chk({tag, "_nissue"}, q_raddr.size(), l + 1);
    chk({tag, "_max_out"}, max_out, (l >= 1) ? 2 : 1);
    chk({tag, "_stable"}, n_unstable, 0);
    chk({tag, "_idle_valid"}, int'(rd_valid), 0);
    obs_last = '0; exp_last = '0; exp_last[l] = 1'b1;
    for (int i = 0; i < q_rdata.size() && i <= l; i++) begin
      obs_last[i] = q_rlast[i];
      chkd($sformatf("%s_rdata%0d", tag, i), q_rdata[i], ref_mem[(a + i) % 64]);
    end
    for (int i = 0; i < q_raddr.size() && i <= l; i++)
      chk($sformatf("%s_raddr%0d", tag, i), int'(q_raddr[i]), (a + i) % 64);
    chkd({tag, "_rlast"}, obs_last, exp_last);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gord[4], gcyc[4], ng, guard, i, e_ord[3], e_d1, e_d2, e_nw, e_nr;
    logic [511:0] d, b0, b1;
    n_pass = 0; n_fail = 0; n_total = 0; n_cyc = 0;
    first_rv = -1; first_iss = -1; hold_prev = 0;
    for (int k = 0; k < 64; k++) begin tb_mem[k] = '0; ref_mem[k] = '0; end
    rst_n = 1'b0; wr_req = 0; rd_req = 0; wr_valid = 0; rd_ready = 0;
    wr_addr = '0; wr_len = '0; rd_addr = '0; rd_len = '0; wr_data = '0;

    repeat (2) cyc();
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_gnts", int'({wr_gnt, rd_gnt, wr_done}), 0);
    chk("rst_rd_valid", int'({rd_valid, rd_last}), 0);
    chk("rst_mem_ctl", int'({mem_en, mem_we, mem_addr}), 0);
    chkd("rst_mem_wdata", mem_wdata, '0);
    chkd("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    cyc();
    chk("idle_outputs", int'({wr_ready, wr_gnt, rd_gnt, rd_valid, mem_en}), 0);

    do_write(5, 3, 2, "wr5");
    do_read(5, 3, 0, "rd5");
    do_write(62, 3, 0, "wrap");
    do_read(62, 3, 2, "wraprd");
    do_write(10, 7, 1, "bpw");
    do_read(10, 7, 1, "bp");
    do_write(20, 0, 0, "w1");
    do_read(20, 0, 0, "r1");
    for (int t = 0; t < 6; t++) begin
      int a, l;
      a = int'($urandom_range(0, 63));
      l = int'($urandom_range(0, 15));
      do_write(a, l, 1, $sformatf("rw%0d", t));
      do_read(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), 2, $sformatf("rr%0d", t));
    end
    do_write(30, 255, 0, "wlong");
    do_read(30, 255, 2, "rlong");

    // Contention: each side re-requests right after its grant
`ifdef ARB_WR_PRIORITY_EN
    e_ord = '{0, 0, 0}; e_d1 = 3; e_d2 = 3; e_nw = 3; e_nr = 1;
`else
    e_ord = '{0, 1, 0}; e_d1 = 3; e_d2 = 5; e_nw = 2; e_nr = 2;
`endif
    d = rnd512();
    q_wdata.delete(); q_rdata.delete();
    wr_addr = 6'd40; wr_len = 8'd0; rd_addr = 6'd40; rd_len = 8'd0;
    wr_data = d; wr_valid = 1'b1; rd_ready = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    ng = 0; guard = 0;
    while (ng < 4 && guard < 100) begin
      cyc(); guard++;
      if (s_wr_gnt) begin gord[ng] = 0; gcyc[ng] = s_cyc; ng++; wr_req = 1'b0; end
      else if (ng < 3 && !wr_req) wr_req = 1'b1;
      if (s_rd_gnt) begin gord[ng] = 1; gcyc[ng] = s_cyc; ng++; rd_req = 1'b0; end
      else if (ng < 3 && !rd_req) rd_req = 1'b1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (8) cyc();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("cont_ngrants", ng, 4);
    for (int k = 0; k < 3; k++) chk($sformatf("cont_order%0d", k), gord[k], e_ord[k]);
    chk("cont_space1", gcyc[1] - gcyc[0], e_d1);
    chk("cont_space2", gcyc[2] - gcyc[1], e_d2);
    chk("cont_nwrites", q_wdata.size(), e_nw);
    chk("cont_nreads", q_rdata.size(), e_nr);
    ref_mem[40] = d;
    for (int k = 0; k < q_rdata.size(); k++) chkd($sformatf("cont_rdata%0d", k), q_rdata[k], d);

    // Reset in the middle of an 8-beat write, after two beats
    b0 = rnd512(); b1 = rnd512();
    wr_addr = 6'd50; wr_len = 8'd7; wr_req = 1'b1; g_wr = -1; guard = 0;
    while (g_wr < 0 && guard < 20) begin cyc(); guard++; end
    chk("rst_mid_wgnt", int'(g_wr >= 0), 1);
    wr_req = 1'b0; q_waddr.delete(); n_done = 0; i = 0; guard = 0;
    while (i < 2 && guard < 50) begin
      wr_valid = 1'b1; wr_data = (i == 0) ? b0 : b1;
      cyc(); guard++;
      if (s_wr_hs) i++;
    end
    wr_data = rnd512();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_ready", int'(wr_ready), 0);
    chk("rst_mid_mem_ctl", int'({mem_en, mem_we, mem_addr}), 0);
    chkd("rst_mid_mem_wdata", mem_wdata, '0);
    chk("rst_mid_flags", int'({wr_done, rd_valid, wr_gnt}), 0);
    wr_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("rst_mid_no_done", n_done, 0);
    chk("rst_mid_nwrites", q_waddr.size(), 2);
    ref_mem[50] = b0; ref_mem[51] = b1;
    do_read(50, 1, 0, "rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
